// File: rtl/serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// serial_adder_nbit
//   Digit-serial adder. Computes {carry,sum} = a + b + cin over WIDTH/DIGIT
//   clock cycles, DIGIT bits per cycle. One DIGIT-bit adder slice and one
//   carry flop are reused every cycle. Handshake is start / busy / done.
//
// Parameters
//   WIDTH  operand and sum width (>= 1)
//   DIGIT  bits added per cycle (1..WIDTH, must divide WIDTH)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   a, b   in   WIDTH  operands, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse, sum/carry updated this cycle
//   sum    out  WIDTH  result, held until the next completion
//   carry  out  1      carry-out of bit WIDTH-1, held with sum
//   ovf    out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the ovf port and its capture logic.
// ---------------------------------------------------------------------------

// One DIGIT-bit slice of the adder: {co,s} = x + y + ci.
module serial_adder_slice #(
    parameter int D = 1
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{D{1'b0}}, ci};
endmodule

module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder_nbit: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A, doubles as result shift reg
    logic [WIDTH-1:0] b_q, b_d;       // operand B shift reg
    logic             c_q, c_d;       // inter-digit carry flop
    logic [CW-1:0]    cnt_q, cnt_d;   // digit step counter
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             am_q, am_d;     // captured sign bits: the shift regs lose them
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] res_next;
    logic             last;

    serial_adder_slice #(.D(DIGIT)) u_slice (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .ci (c_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // A is consumed from the LSB end while result digits enter from the MSB
    // end, so after N steps the register holds the complete sum in order.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign res_next = slice_s;
    end else begin : g_multi_digit
        assign res_next = {slice_s, a_q[WIDTH-1:DIGIT]};
    end

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = res_next;
                b_d   = b_q >> DIGIT;
                c_d   = slice_co;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = res_next;
                    carry_d = slice_co;
                    done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (am_q == bm_q) && (res_next[WIDTH-1] != am_q);
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_nbit
//   Directed bench for serial_adder_nbit. Three instances:
//     u8  : WIDTH=8, DIGIT=1 (N=8)
//     u42 : WIDTH=4, DIGIT=2 (N=2), exhaustive {a,b,cin} sweep
//     u44 : WIDTH=4, DIGIT=4 (N=1)
//   Honours SERIAL_ADDER_OVF_EN for the ovf checks.
// ---------------------------------------------------------------------------
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       start42, start44, cin4;
    logic [3:0] a4, b4;
    logic       busy42, done42, carry42, busy44, done44, carry44;
    logic [3:0] sum42, sum44;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf42, ovf44;
`endif

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder_nbit #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst_n(rst_n), .start(start42), .a(a4), .b(b4), .cin(cin4),
        .busy(busy42), .done(done42), .sum(sum42), .carry(carry42)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf42)
`endif
    );

    serial_adder_nbit #(.WIDTH(4), .DIGIT(4)) u44 (
        .clk(clk), .rst_n(rst_n), .start(start44), .a(a4), .b(b4), .cin(cin4),
        .busy(busy44), .done(done44), .sum(sum44), .carry(carry44)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf44)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start one op on u8 and return the number of edges from the accepting
    // edge until done is seen (40 = timed out).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Same for the 4-bit instances: sel=0 -> u42, sel=1 -> u44.
    task automatic op4(input bit sel, input logic [3:0] a, input logic [3:0] b, input logic c,
                       output int lat, output logic [4:0] res);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c;
        if (sel) start44 = 1'b1; else start42 = 1'b1;
        @(posedge clk); #1;
        start42 = 1'b0; start44 = 1'b0;
        lat = 0;
        while ((sel ? done44 : done42) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = sel ? {carry44, sum44} : {carry42, sum42};
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_carry;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         lat, n, ndone, kdone;
        logic [4:0] res;
        logic [3:0] ta, tb4;
        logic       tc;
        logic [7:0] cap_sum;
        logic       cap_carry;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; start42 = 1'b0; start44 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset state
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_carry", 32'(carry8), 32'd0);
        check("rst_busy42", 32'(busy42), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf8), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of 8-bit vectors, including the ovf cases
        for (int i = 0; i < 9; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_sum", i), 32'(sum8), 32'(vecs[i].exp_sum));
            check($sformatf("v%0d_carry", i), 32'(carry8), 32'(vecs[i].exp_carry));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vecs[i].exp_ovf));
`endif
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), 32'(done8), 32'd0);
        end

        // Exhaustive 4-bit sweep with DIGIT=2, plus a sample with DIGIT=WIDTH
        for (int k = 0; k < 512; k++) begin
            {ta, tb4, tc} = 9'(k);
            op4(1'b0, ta, tb4, tc, lat, res);
            check($sformatf("w4d2_%0d_res", k), 32'(res), 32'(5'(ta) + 5'(tb4) + 5'(tc)));
            check($sformatf("w4d2_%0d_lat", k), 32'(lat), 32'd2);
        end
        for (int k = 0; k < 512; k += 37) begin
            {ta, tb4, tc} = 9'(k);
            op4(1'b1, ta, tb4, tc, lat, res);
            check($sformatf("w4d4_%0d_res", k), 32'(res), 32'(5'(ta) + 5'(tb4) + 5'(tc)));
            check($sformatf("w4d4_%0d_lat", k), 32'(lat), 32'd1);
        end

        // Start pulse with new operands while busy must be ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("ign_busy_after_start", 32'(busy8), 32'd1);
        ndone = 0; kdone = -1; cap_sum = '0; cap_carry = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 2) begin
                @(negedge clk);
                a8 = 8'hAA; start8 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                ndone++;
                if (kdone < 0) begin
                    kdone = k;
                    cap_sum = sum8;
                    cap_carry = carry8;
                end
            end
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_done_edge", 32'(kdone), 32'd7);
        check("ign_sum", 32'(cap_sum), 32'h46);
        check("ign_carry", 32'(cap_carry), 32'd0);

        // Held start: back-to-back operations every N+1 cycles
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done8 !== 1'b1 && n < 40);
        check("held_first_edges", 32'(n), 32'd9);
        check("held_sum", 32'(sum8), 32'h01);
        check("held_carry", 32'(carry8), 32'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done8 !== 1'b1 && n < 40);
        check("held_period", 32'(n), 32'd9);
        check("held_sum2", 32'(sum8), 32'h01);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("held_release_idle", 32'(busy8), 32'd0);

        // Asynchronous reset mid-operation aborts without a done pulse
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_carry", 32'(carry8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        op8(8'h12, 8'h34, 1'b0, lat);
        check("post_abort_lat", 32'(lat), 32'd8);
        check("post_abort_sum", 32'(sum8), 32'h46);
        check("post_abort_carry", 32'(carry8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
